drain_sequencer: RTL and testbench

- Sequences read-out of the N x N PE accumulator array after a drain instruction leaves the control block.
- Waits for the array pipeline to settle, then streams the array bottom row out one row per valid/ready handshake, shifting the accumulators down after each accepted row.
- Clears the accumulators once all rows are out, then signals completion.
- Sits between the control output (fetch.drain) and the PE array / result write-back port.

---
 rtl/drain_sequencer_pkg.sv | 8 +
 rtl/drain_sequencer.sv | 63 ++++++
 tb/tb_drain_sequencer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/drain_sequencer_pkg.sv
// drain_sequencer_pkg: shared state type and array geometry for the drain sequencer
package drain_sequencer_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, EMIT, CLEAR} drain_state_t;
  localparam int ARRAY_N = 4;
  localparam int ACC_W = 32;
  localparam int T_D = 2 * ARRAY_N - 1;
  localparam int SETTLE_DEF = T_D;
endpackage

// File: rtl/drain_sequencer.sv
// drain_sequencer: streams PE accumulator rows out after a drain request, then clears the array
module drain_sequencer
  import drain_sequencer_pkg::*;
#(
  parameter int N = ARRAY_N,
  parameter int DATA_W = ACC_W,
  parameter int SETTLE_CYCLES = SETTLE_DEF,
  localparam int RW = N > 1 ? $clog2(N) : 1,
  localparam int SW = $clog2(SETTLE_CYCLES + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                drain_req_i,
  output logic                drain_ready_o,
  input  logic [N*DATA_W-1:0] row_data_i,
  output logic                pe_shift_o,
  output logic                pe_clear_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [N*DATA_W-1:0] out_data_o,
  output logic [RW-1:0]       out_row_o,
  output logic                busy_o,
  output logic                done_o
);
  drain_state_t state;
  logic [SW-1:0] settle_cnt;
  logic [RW-1:0] row_cnt;
  logic emit;
  assign emit = state == EMIT;
  assign drain_ready_o = state == IDLE;
  assign busy_o = state != IDLE;
  assign out_valid_o = emit;
  // the array only moves on an accepted row, so the pass-through stays stable under backpressure
  assign pe_shift_o = emit && out_ready_i;
  assign pe_clear_o = state == CLEAR;
  assign out_data_o = emit ? row_data_i : '0;
  assign out_row_o = emit ? row_cnt : '0;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      settle_cnt <= '0;
      row_cnt <= '0;
      done_o <= 1'b0;
    end else begin
      done_o <= state == CLEAR;
      case (state)
        IDLE: if (drain_req_i) begin
          state <= SETTLE;
          settle_cnt <= SW'(SETTLE_CYCLES - 1);
          row_cnt <= '0;
        end
        SETTLE: if (settle_cnt == '0) state <= EMIT;
                else settle_cnt <= settle_cnt - 1'b1;
        EMIT: if (out_ready_i) begin
          if (row_cnt == RW'(N - 1)) state <= CLEAR;
          else row_cnt <= row_cnt + 1'b1;
        end
        CLEAR: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_drain_sequencer.sv
// tb_drain_sequencer: randomized bench against a timeline model of the drain sequence
module tb_drain_sequencer;
  localparam int N = 4;
  localparam int S = 7;
  localparam int W = 32;
  localparam int DW = N * W;
  logic clk = 0, rst = 1, req = 0, rdy = 0;
  logic [DW-1:0] row_data = '0;
  logic drain_ready, pe_shift, pe_clear, out_valid, busy, done;
  logic [DW-1:0] out_data;
  logic [1:0] out_row;
  int vectors = 0, miscompares = 0;
  bit m_active = 0;
  int m_acc = 0, m_rows = 0, m_done_at = -1, cyc = 0;
  logic [DW-1:0] rows [N];
  logic e_settle, e_emit, e_clear, e_ready, e_done, e_shift;
  logic [7:0] exp_ctrl, dut_ctrl;
  logic [DW-1:0] exp_data;
  drain_sequencer #(.N(N), .DATA_W(W), .SETTLE_CYCLES(S)) dut (
    .clk_i(clk), .rst_i(rst), .drain_req_i(req), .drain_ready_o(drain_ready),
    .row_data_i(row_data), .pe_shift_o(pe_shift), .pe_clear_o(pe_clear),
    .out_valid_o(out_valid), .out_ready_i(rdy), .out_data_o(out_data),
    .out_row_o(out_row), .busy_o(busy), .done_o(done)
  );
  always #5 clk = ~clk;
  // expected behaviour as a timeline: S settle cycles after acceptance, N accepted rows, one clear
  always_comb begin
    e_settle = m_active && (cyc - m_acc) <= S;
    e_clear = m_active && m_rows == N;
    e_emit = m_active && !e_settle && m_rows < N;
    e_ready = !m_active;
    e_done = cyc == m_done_at;
    e_shift = e_emit && rdy;
    exp_ctrl = {e_ready, !e_ready, e_emit, e_shift, e_clear, e_done, e_emit ? m_rows[1:0] : 2'd0};
    exp_data = e_emit ? row_data : '0;
  end
  assign dut_ctrl = {drain_ready, busy, out_valid, pe_shift, pe_clear, done, out_row};
  task automatic drive(input bit q, input bit r);
    req = q;
    rdy = r;
    row_data = (m_active && m_rows < N) ? rows[m_rows] : {$urandom, $urandom, $urandom, $urandom};
    #1;
  endtask
  task automatic tick();
    bit s_ready, s_shift, s_clear, s_req, s_rst;
    s_ready = e_ready; s_shift = e_shift; s_clear = e_clear; s_req = req; s_rst = rst;
    @(posedge clk);
    if (s_rst) begin
      m_active = 0; m_rows = 0; m_done_at = -1;
    end else if (s_ready && s_req) begin
      m_active = 1; m_acc = cyc; m_rows = 0;
      for (int i = 0; i < N; i++) rows[i] = {$urandom, $urandom, $urandom, $urandom};
    end else if (s_shift) m_rows++;
    else if (s_clear) begin
      m_active = 0; m_done_at = cyc + 1;
    end
    cyc++;
    @(negedge clk);
  endtask
  task automatic test_reset();
    rst = 1;
    drive(0, 0); tick(); tick();
    rst = 0;
    for (int k = 0; k < 3; k++) begin
      drive(0, 1);
      vectors++;
      if (dut_ctrl !== 8'b1000_0000 || out_data !== '0) begin
        miscompares++;
        $display("FAIL reset k=%0d ctrl=%b required=%b data=%h", k, dut_ctrl, 8'b1000_0000, out_data);
      end
      tick();
    end
  endtask
  task automatic test_basic();
    for (int k = 0; k <= S + N + 3; k++) begin
      drive(k == 0, 1);
      vectors++;
      if (dut_ctrl !== exp_ctrl || out_data !== exp_data) begin
        miscompares++;
        $display("FAIL basic k=%0d ctrl=%b required=%b data=%h required=%h", k, dut_ctrl, exp_ctrl, out_data, exp_data);
      end
      vectors++;
      if (out_valid !== (k >= S + 1 && k <= S + N) || pe_clear !== (k == S + N + 1) || done !== (k == S + N + 2)) begin
        miscompares++;
        $display("FAIL basic_timing k=%0d valid=%b clear=%b done=%b", k, out_valid, pe_clear, done);
      end
      tick();
    end
  endtask
  task automatic test_backpressure();
    int stalls = 0, dones = 0;
    logic [DW-1:0] held;
    for (int k = 0; k < 25; k++) begin
      drive(k == 0, !(e_emit && m_rows == 1 && stalls < 5));
      if (!rdy) begin
        if (stalls == 0) held = out_data;
        stalls++;
        vectors++;
        if (pe_shift !== 1'b0 || out_valid !== 1'b1 || out_row !== 2'd1 || out_data !== held) begin
          miscompares++;
          $display("FAIL stall k=%0d shift=%b valid=%b row=%0d data=%h held=%h", k, pe_shift, out_valid, out_row, out_data, held);
        end
      end
      dones += done;
      vectors++;
      if (dut_ctrl !== exp_ctrl || out_data !== exp_data) begin
        miscompares++;
        $display("FAIL backpressure k=%0d ctrl=%b required=%b data=%h required=%h", k, dut_ctrl, exp_ctrl, out_data, exp_data);
      end
      tick();
    end
    vectors++;
    if (dones != 1 || stalls != 5) begin
      miscompares++;
      $display("FAIL backpressure_done dones=%0d stalls=%0d required 1 and 5", dones, stalls);
    end
  endtask
  task automatic test_busy_req();
    bit restarted = 0, saw_done = 0;
    for (int k = 0; k < S + N + 24; k++) begin
      drive(k == 0 || (k <= S + 2 && $urandom_range(0, 1) == 1) || (k >= S + 3 && !saw_done), 1);
      if (k >= 1 && k <= S + N) begin
        vectors++;
        if (drain_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL busy_ready k=%0d ready=%b required 0", k, drain_ready);
        end
      end
      vectors++;
      if (dut_ctrl !== exp_ctrl || out_data !== exp_data) begin
        miscompares++;
        $display("FAIL busy_req k=%0d ctrl=%b required=%b data=%h required=%h", k, dut_ctrl, exp_ctrl, out_data, exp_data);
      end
      if (saw_done && !restarted) begin
        restarted = 1;
        vectors++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL restart k=%0d busy=%b valid=%b required 1 and 0", k, busy, out_valid);
        end
      end
      if (done && !saw_done) saw_done = 1;
      tick();
    end
    vectors++;
    if (!restarted) begin
      miscompares++;
      $display("FAIL restart_seen got 0 required 1");
    end
  endtask
  task automatic test_reset_mid();
    int k = 0;
    while (!(e_emit && m_rows == 2) && k < 30) begin
      drive(k == 0, 1);
      tick();
      k++;
    end
    vectors++;
    if (k >= 30 || out_row !== 2'd2 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_reach k=%0d row=%0d valid=%b required row 2 valid 1", k, out_row, out_valid);
    end
    rst = 1;
    drive(0, 0);
    tick();
    rst = 0;
    for (int j = 0; j < 4; j++) begin
      drive(0, 1);
      vectors++;
      if (dut_ctrl !== 8'b1000_0000 || dut_ctrl !== exp_ctrl) begin
        miscompares++;
        $display("FAIL reset_mid j=%0d ctrl=%b required=%b", j, dut_ctrl, 8'b1000_0000);
      end
      tick();
    end
  endtask
  task automatic test_passthrough();
    logic [DW-1:0] pat;
    bit hit = 0;
    pat = 128'h00000004_00000003_00000002_00000001;
    for (int k = 0; k <= S + N + 3; k++) begin
      if (k == 1) rows[0] = pat;
      drive(k == 0, 1);
      if (e_shift && m_rows == 0) begin
        hit = 1;
        vectors++;
        if (out_data !== pat) begin
          miscompares++;
          $display("FAIL passthrough data=%h required=%h", out_data, pat);
        end
      end
      vectors++;
      if (dut_ctrl !== exp_ctrl || out_data !== exp_data) begin
        miscompares++;
        $display("FAIL passthrough_seq k=%0d ctrl=%b required=%b data=%h required=%h", k, dut_ctrl, exp_ctrl, out_data, exp_data);
      end
      tick();
    end
    vectors++;
    if (!hit) begin
      miscompares++;
      $display("FAIL passthrough_hit got 0 required 1");
    end
  endtask
  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      rst = $urandom_range(0, 96) == 0;
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0);
      vectors++;
      if (dut_ctrl !== exp_ctrl || out_data !== exp_data) begin
        miscompares++;
        $display("FAIL random k=%0d ctrl=%b required=%b data=%h required=%h", k, dut_ctrl, exp_ctrl, out_data, exp_data);
      end
      tick();
    end
    rst = 0;
  endtask
  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_busy_req();
    test_reset_mid();
    test_passthrough();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
